// File: rtl/udp_wide_unpack_if.sv
// Beat-in / frame-out handshake bundle for udp_wide_unpack.
// slave is the unpacker's view; master is the producer/consumer side.
interface udp_wide_unpack_if #(
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned NBEATS = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [BEAT_W-1:0]          in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [BEAT_W*NBEATS-1:0]   out_vec;
  logic [3:0]                 out_m;
  logic [3:0]                 out_sm;
  logic [9:0]                 out_r;
  logic [9:0]                 out_sr;
  logic                       err_len;
  logic                       err_chk;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_vec, out_m, out_sm, out_r, out_sr, err_len, err_chk
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_vec, out_m, out_sm, out_r, out_sr, err_len, err_chk
  );
endinterface

// File: rtl/udp_wide_unpack.sv
// Reassembles a 128-bit result vector from 8-bit beats, decodes the packed gate-result
// field, flags length/consistency errors and keeps saturating frame/error counters.
module udp_wide_unpack #(
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned NBEATS = 16
) (
  input  logic                clk,
  input  logic                rst,
  udp_wide_unpack_if.slave    bus,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         err_cnt
);
  localparam int unsigned VecW = BEAT_W * NBEATS;
  localparam int unsigned IdxW = $clog2(NBEATS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBEATS - 1);

  typedef enum logic {StCollect, StHold} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [VecW-1:0]   asm_q, asm_d;
  logic [VecW-1:0]   vec_q, vec_d;
  logic              err_len_q, err_len_d;
  logic              err_chk_q, err_chk_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [VecW-1:0]   merged;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    vec_d       = vec_q;
    err_len_d   = err_len_q;
    err_chk_d   = err_chk_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    merged      = asm_q;
    merged[idx_q*BEAT_W +: BEAT_W] = bus.in_data;

    unique case (state_q)
      StCollect: begin
        if (bus.in_valid) begin
          asm_d = merged;
          idx_d = idx_q + IdxW'(1);
          if (bus.in_last || idx_q == LastIdx) begin
            state_d   = StHold;
            vec_d     = merged;
            // Only a last flag landing exactly on the final beat is a clean length.
            err_len_d = !(bus.in_last && idx_q == LastIdx);
            err_chk_d = (|merged[VecW-1:28]) || (merged[27] != merged[19])
                        || (merged[19] != merged[9]);
          end
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d     = StCollect;
          idx_d       = '0;
          asm_d       = '0;
          err_len_d   = 1'b0;
          err_chk_d   = 1'b0;
          frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
          if (err_len_q || err_chk_q) begin
            err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCollect;
      idx_q       <= '0;
      asm_q       <= '0;
      vec_q       <= '0;
      err_len_q   <= 1'b0;
      err_chk_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      vec_q       <= vec_d;
      err_len_q   <= err_len_d;
      err_chk_q   <= err_chk_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StCollect);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_vec   = vec_q;
  assign bus.out_m     = vec_q[27:24];
  assign bus.out_sm    = vec_q[23:20];
  assign bus.out_r     = vec_q[19:10];
  assign bus.out_sr    = vec_q[9:0];
  assign bus.err_len   = bus.out_valid & err_len_q;
  assign bus.err_chk   = bus.out_valid & err_chk_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_udp_wide_unpack.sv
// Scoreboard bench for udp_wide_unpack: directed frames push expected results, a monitor
// pops and compares on each output handshake.
module tb_udp_wide_unpack;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame_cnt, err_cnt;

  udp_wide_unpack_if #(.BEAT_W(8), .NBEATS(16)) bus ();

  udp_wide_unpack #(.BEAT_W(8), .NBEATS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] vec;
    logic         el;
    logic         ec;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_frames = 0;
  logic [15:0] exp_errs = 0;
  bit          cnt_pending = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: handshake happens on the posedge following a negedge where both are high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cnt_pending) begin
        chk("frame_cnt", frame_cnt, exp_frames);
        chk("err_cnt", err_cnt, exp_errs);
        cnt_pending = 0;
      end
      if (!rst && !bus.out_valid && (bus.err_len || bus.err_chk)) begin
        chk("err_idle", {bus.err_len, bus.err_chk}, 2'b00);
      end
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_vec", bus.out_vec, e.vec);
          chk("out_m", bus.out_m, e.vec[27:24]);
          chk("out_sm", bus.out_sm, e.vec[23:20]);
          chk("out_r", bus.out_r, e.vec[19:10]);
          chk("out_sr", bus.out_sr, e.vec[9:0]);
          chk("err_len", bus.err_len, e.el);
          chk("err_chk", bus.err_chk, e.ec);
          if (exp_frames != 16'hFFFF) exp_frames++;
          if ((e.el || e.ec) && exp_errs != 16'hFFFF) exp_errs++;
          cnt_pending = 1;
        end
      end
    end
  end

  task automatic wait_accept();
    bit acc;
    int t = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 100);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [7:0] d[16], input int n, input int last_at,
                            input bit push, input logic [127:0] ev, input bit el,
                            input bit ec);
    exp_t e;
    if (push) begin
      e.vec = ev; e.el = el; e.ec = ec;
      exp_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      bus.in_last  = (i == last_at);
      wait_accept();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'h00;
    if (push) chk("latency_out_valid", bus.out_valid, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  b[16];
    logic [127:0] snap_vec;
    logic [15:0]  snap_cnt;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_vec", bus.out_vec, 0);
    chk("rst_err_len", bus.err_len, 0);
    chk("rst_err_chk", bus.err_chk, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;

    // Nominal: m1=r1=1, sr1=0 -> consistency error
    foreach (b[i]) b[i] = 8'h00;
    b[3] = 8'h08; b[2] = 8'h08;
    send_frame(b, 16, 15, 1, 128'h0808_0000, 0, 1);

    // Consistent: sr1 also set
    b[1] = 8'h02;
    send_frame(b, 16, 15, 1, 128'h0808_0200, 0, 0);

    // Short frame
    foreach (b[i]) b[i] = 8'h00;
    for (int i = 0; i < 4; i++) b[i] = 8'hFF;
    send_frame(b, 4, 3, 1, 128'hFFFF_FFFF, 1, 1);

    // Long frame: closes at beat 15 without last, next frame clean
    foreach (b[i]) b[i] = 8'h00;
    send_frame(b, 16, -1, 1, 128'h0, 1, 0);
    b[1] = 8'h02; b[2] = 8'h08; b[3] = 8'h08;
    send_frame(b, 16, 15, 1, 128'h0808_0200, 0, 0);

    // m1 set alone
    foreach (b[i]) b[i] = 8'h00;
    b[3] = 8'h08;
    send_frame(b, 16, 15, 1, 128'h0800_0000, 0, 1);

    // Upper bits nonzero
    foreach (b[i]) b[i] = 8'h00;
    b[15] = 8'h80;
    send_frame(b, 16, 15, 1, {8'h80, 120'h0}, 0, 1);
    drain();

    // Backpressure
    bus.out_ready = 1'b0;
    foreach (b[i]) b[i] = 8'h00;
    b[0] = 8'h5A; b[1] = 8'h02; b[2] = 8'h08; b[3] = 8'h08;
    send_frame(b, 16, 15, 1, 128'h0808_025A, 0, 0);
    snap_vec = bus.out_vec;
    snap_cnt = frame_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_vec", bus.out_vec, snap_vec);
      chk("bp_frame_cnt", frame_cnt, snap_cnt);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();
    chk("bp_frame_cnt_inc", frame_cnt, snap_cnt + 16'd1);

    // Reset mid-frame
    foreach (b[i]) b[i] = 8'hAA;
    send_frame(b, 8, -1, 0, 128'h0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_frames = 0; exp_errs = 0; cnt_pending = 0;
    chk("mr_frame_cnt", frame_cnt, 0);
    chk("mr_err_cnt", err_cnt, 0);
    chk("mr_out_valid", bus.out_valid, 0);
    chk("mr_in_ready", bus.in_ready, 1);
    foreach (b[i]) b[i] = 8'h00;
    b[1] = 8'h02; b[2] = 8'h08; b[3] = 8'h08;
    send_frame(b, 16, 15, 1, 128'h0808_0200, 0, 0);
    drain();
    chk("final_frame_cnt", frame_cnt, 1);
    chk("final_err_cnt", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "timeout");
  end
endmodule
